// File: rtl/rpn_stack_unit_pkg.sv
// Shared types for the RPN stack unit: opcodes, error codes and FSM states.
package rpn_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 1024;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_NEG  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_MUL  = 3'd5,
        OP_POP  = 3'd6,
        OP_SWAP = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2
    } err_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/rpn_stack_unit_if.sv
// Command channel into the stack unit: valid/ready handshake plus opcode and operand.
interface rpn_stack_unit_if #(
    parameter int unsigned WIDTH = rpn_pkg::DEF_WIDTH
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    rpn_pkg::op_t     cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/rpn_stack_unit_seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles total.
// The first step is taken on the start edge, so done is high in the WIDTH-th
// cycle after start and p already holds the low WIDTH bits of a*b.
module seq_multiplier #(
    parameter int unsigned WIDTH = rpn_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int unsigned SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic             busy;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // Accumulate shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            step   <= '0;
            mcand  <= '0;
            mplier <= '0;
            p      <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                step   <= SW'(1);
                p      <= b[0] ? a : '0;
                mcand  <= a << 1;
                mplier <= b >> 1;
            end else if (busy) begin
                if (mplier[0]) begin
                    p <= p + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                step   <= step + SW'(1);
                if (step == SW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rpn_stack_unit.sv
// Reverse-Polish stack calculator: top-of-stack register over a spill memory,
// single-cycle ops plus an iterative multiply, with sticky error reporting.
module rpn_stack_unit
    import rpn_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    rpn_stack_unit_if.slave  cmd,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] depth_cnt,
    output logic             err,
    output err_t             err_code
);
    // Memory holds S1 and below; one spare entry keeps the index a clean AW bits.
    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] s1_c;
    logic             accept_c;
    logic             under_c;
    logic             over_c;
    logic             exec_c;
    logic             mem_we_c;
    logic [AW-1:0]    mem_wa_c;
    logic             mul_start_c;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    assign cmd.cmd_ready = (state == ST_IDLE);

    // Decode the offered command: error detection, spill write and multiply start
    always_comb begin
        s1_c        = mem[AW'(depth_cnt - CNT_W'(2))];
        accept_c    = cmd.cmd_valid && (state == ST_IDLE);
        under_c     = 1'b0;
        over_c      = 1'b0;
        mem_we_c    = 1'b0;
        mem_wa_c    = AW'(depth_cnt - CNT_W'(1));
        case (cmd.cmd_op)
            OP_NEG, OP_POP:                 under_c = (depth_cnt == '0);
            OP_ADD, OP_SUB, OP_MUL, OP_SWAP: under_c = (depth_cnt < CNT_W'(2));
            OP_PUSH:                        over_c  = (depth_cnt == CNT_W'(DEPTH));
            default:                        ;
        endcase
        under_c = under_c && accept_c;
        over_c  = over_c && accept_c;
        exec_c  = accept_c && !under_c && !over_c;
        if (exec_c && cmd.cmd_op == OP_PUSH && depth_cnt != '0) begin
            mem_we_c = 1'b1;
        end
        if (exec_c && cmd.cmd_op == OP_SWAP) begin
            mem_we_c = 1'b1;
            mem_wa_c = AW'(depth_cnt - CNT_W'(2));
        end
        mul_start_c = exec_c && (cmd.cmd_op == OP_MUL);
    end

    // Old S0 goes down into memory on PUSH (spill) and SWAP
    always_ff @(posedge clk) begin
        if (nrst && mem_we_c) begin
            mem[mem_wa_c] <= top;
        end
    end

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .nrst  (nrst),
        .start (mul_start_c),
        .a     (s1_c),
        .b     (top),
        .done  (mul_done),
        .p     (mul_p)
    );

    // FSM, top register, element counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            top       <= '0;
            depth_cnt <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exec_c) begin
                        case (cmd.cmd_op)
                            OP_PUSH: begin
                                top       <= cmd.cmd_data;
                                depth_cnt <= depth_cnt + CNT_W'(1);
                            end
                            OP_NEG: top <= -top;
                            OP_ADD: begin
                                top       <= s1_c + top;
                                depth_cnt <= depth_cnt - CNT_W'(1);
                            end
                            OP_SUB: begin
                                top       <= s1_c - top;
                                depth_cnt <= depth_cnt - CNT_W'(1);
                            end
                            OP_MUL: state <= ST_MUL;
                            OP_POP: begin
                                top       <= (depth_cnt == CNT_W'(1)) ? '0 : s1_c;
                                depth_cnt <= depth_cnt - CNT_W'(1);
                            end
                            OP_SWAP: top <= s1_c;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        top       <= mul_p;
                        depth_cnt <= depth_cnt - CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A new error beats a simultaneous clear and records its own code
            if (under_c || over_c) begin
                err <= 1'b1;
                if (!err || err_clr) begin
                    err_code <= under_c ? ERR_UNDER : ERR_OVER;
                end
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_rpn_stack_unit.sv
// Directed bench for rpn_stack_unit (WIDTH=16, DEPTH=4).
module tb_rpn_stack_unit;
    import rpn_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             nrst;
    logic             err_clr;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] depth_cnt;
    logic             err;
    err_t             err_code;

    int checks   = 0;
    int failures = 0;

    rpn_stack_unit_if #(.WIDTH(WIDTH)) cmd_if ();

    rpn_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd       (cmd_if),
        .err_clr   (err_clr),
        .top       (top),
        .depth_cnt (depth_cnt),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_stack(input string tag, input logic [15:0] top_e, input int cnt_e);
        check({tag, "_top"}, 32'(top), 32'(top_e));
        check({tag, "_cnt"}, 32'(depth_cnt), 32'(cnt_e));
    endtask

    // Offer one command, wait (bounded) for acceptance, return at the next negedge
    task automatic do_cmd(input op_t op, input logic [15:0] d);
        int waited = 0;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        while (!cmd_if.cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_if.cmd_ready) check("ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        int hold_errs;

        nrst             = 1'b0;
        err_clr          = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_PUSH;
        cmd_if.cmd_data  = 16'h0009;

        // Reset with a PUSH offered: nothing may be accepted
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst             = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check_stack("rst", 16'h0000, 0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'(ERR_NONE));
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

        // Underflow then overflow: first code is kept
        do_cmd(OP_ADD, 16'h0);
        check("under_err", 32'(err), 32'd1);
        check("under_code", 32'(err_code), 32'(ERR_UNDER));
        check("under_cnt", 32'(depth_cnt), 32'd0);
        for (int i = 1; i <= 4; i++) do_cmd(OP_PUSH, 16'(i));
        check_stack("fill", 16'h0004, 4);
        do_cmd(OP_PUSH, 16'h0005);
        check("over_keep_code", 32'(err_code), 32'(ERR_UNDER));
        check_stack("over_keep", 16'h0004, 4);

        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("clr_err", 32'(err), 32'd0);
        check("clr_code", 32'(err_code), 32'(ERR_NONE));

        do_cmd(OP_PUSH, 16'h0005);
        check("over_err", 32'(err), 32'd1);
        check("over_code", 32'(err_code), 32'(ERR_OVER));
        check_stack("over", 16'h0004, 4);

        for (int i = 0; i < 4; i++) begin
            do_cmd(OP_POP, 16'h0);
            check_stack($sformatf("pop%0d", i), 16'(3 - i), 3 - i);
        end

        // Clear in the same cycle as a new underflow: error and new code win
        @(negedge clk);
        err_clr          = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_POP;
        @(posedge clk);
        #1;
        err_clr          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("clr_vs_err", 32'(err), 32'd1);
        check("clr_vs_err_code", 32'(err_code), 32'(ERR_UNDER));
        check_stack("empty_pop", 16'h0000, 0);

        // Basic arithmetic
        do_reset();
        do_cmd(OP_PUSH, 16'd5);
        do_cmd(OP_PUSH, 16'd7);
        do_cmd(OP_ADD, 16'h0);
        check_stack("add", 16'd12, 1);
        do_cmd(OP_PUSH, 16'd3);
        do_cmd(OP_SUB, 16'h0);
        check_stack("sub", 16'd9, 1);
        do_cmd(OP_NOP, 16'hAAAA);
        check_stack("nop", 16'd9, 1);
        do_cmd(OP_MUL, 16'h0);
        check("mul_under_code", 32'(err_code), 32'(ERR_UNDER));
        check("mul_under_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check_stack("mul_under", 16'd9, 1);
        do_cmd(OP_NEG, 16'h0);
        check_stack("neg", 16'hFFF7, 1);

        do_reset();
        do_cmd(OP_PUSH, 16'h8000);
        do_cmd(OP_NEG, 16'h0);
        check_stack("neg_min", 16'h8000, 1);

        // SWAP then SUB
        do_reset();
        do_cmd(OP_PUSH, 16'd10);
        do_cmd(OP_PUSH, 16'd3);
        do_cmd(OP_SWAP, 16'h0);
        check_stack("swap", 16'd10, 2);
        do_cmd(OP_SUB, 16'h0);
        check_stack("swap_sub", 16'hFFF9, 1);
        check("swap_sub_err", 32'(err), 32'd0);

        // Multiply with a PUSH held valid throughout the busy period
        do_cmd(OP_PUSH, 16'd3);
        do_cmd(OP_PUSH, 16'hFFFC);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_MUL;
        @(posedge clk);
        #1;
        cmd_if.cmd_op   = OP_PUSH;
        cmd_if.cmd_data = 16'h0055;
        busy_cycles = 0;
        hold_errs   = 0;
        @(negedge clk);
        while (!cmd_if.cmd_ready && busy_cycles < 40) begin
            busy_cycles++;
            if (top !== 16'hFFFC || depth_cnt !== CNT_W'(3)) hold_errs++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(busy_cycles), 32'd16);
        check("mul_hold", 32'(hold_errs), 32'd0);
        check_stack("mul", 16'hFFF4, 2);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check_stack("held_push", 16'h0055, 3);

        // Reset during the 8th multiply cycle aborts it
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_MUL;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mul8_busy", 32'(cmd_if.cmd_ready), 32'd0);
        nrst = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check_stack("mul_rst", 16'h0000, 0);
        check("mul_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        do_cmd(OP_PUSH, 16'd7);
        check_stack("post_rst_push", 16'd7, 1);
        repeat (20) @(negedge clk);
        check_stack("post_rst_idle", 16'd7, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
